// File: rtl/icache_refill_unit.sv
// Instruction-cache line refill engine.
// On a miss it reads the four words of the missing 16-byte line from
// word-wide memory, always in order 0..3. It presents the assembled
// 128-bit line for one cycle and holds Stall for the whole transfer.
// A word that waits too long for MemReady aborts the refill and sets
// the sticky Error flag.
module icache_refill_unit #(
    parameter int TIMEOUT    = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Miss,
    input  logic [31:0]  MissAddress,
    output logic [31:0]  MemAddr,
    output logic         MemRead,
    input  logic [31:0]  MemRdata,
    input  logic         MemReady,
    output logic [127:0] DataLine,
    output logic         LineValid,
    output logic         Stall,
    output logic         Error
);

    localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [1:0]        WORD_LAST = 2'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [27:0]         line_q, line_d;
    logic [1:0]          word_q, word_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [31:0]         mem_addr_d;
    logic                mem_read_d;
    logic [127:0]        data_line_d;
    logic                line_valid_d;
    logic                stall_d;
    logic                error_d;
    logic [31:0]         slot0_q, slot1_q, slot2_q;

    // The fetch order always starts at word 0, so the byte/word offset of
    // the missing address plays no part in the refill.
    logic unused_low_bits;
    assign unused_low_bits = ^MissAddress[3:0];

    // Next-state and next-output logic for the refill sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        line_d       = line_q;
        word_d       = word_q;
        wait_d       = wait_q;
        mem_addr_d   = MemAddr;
        mem_read_d   = MemRead;
        data_line_d  = DataLine;
        line_valid_d = 1'b0;
        stall_d      = Stall;
        error_d      = Error;

        case (state_q)
            IDLE: begin
                if (Miss) begin
                    line_d     = MissAddress[31:4];
                    word_d     = 2'd0;
                    wait_d     = '0;
                    stall_d    = 1'b1;
                    mem_read_d = 1'b1;
                    mem_addr_d = {MissAddress[31:4], 4'b0000};
                    state_d    = READ;
                end
            end

            READ: begin
                if (MemReady) begin
                    wait_d = '0;
                    if (word_q == WORD_LAST) begin
                        data_line_d  = {MemRdata, slot2_q, slot1_q, slot0_q};
                        line_valid_d = 1'b1;
                        mem_read_d   = 1'b0;
                        state_d      = DONE;
                    end else begin
                        // Advance in the same cycle so zero-wait memory
                        // streams one word per clock.
                        word_d     = word_q + 2'd1;
                        mem_addr_d = {line_q, word_d, 2'b00};
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Give up on this line; DataLine keeps the last good line.
                    error_d    = 1'b1;
                    mem_read_d = 1'b0;
                    stall_d    = 1'b0;
                    state_d    = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            DONE: begin
                stall_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and all outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            word_q    <= 2'd0;
            wait_q    <= '0;
            MemAddr   <= '0;
            MemRead   <= 1'b0;
            DataLine  <= 'x;
            LineValid <= 1'b0;
            Stall     <= 1'b0;
            Error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            word_q    <= word_d;
            wait_q    <= wait_d;
            MemAddr   <= mem_addr_d;
            MemRead   <= mem_read_d;
            DataLine  <= data_line_d;
            LineValid <= line_valid_d;
            Stall     <= stall_d;
            Error     <= error_d;
        end
    end

    // Holding slots for words 0..2; word 3 goes straight into DataLine.
    always_ff @(posedge clk) begin
        // NOTE: the slots are pure data storage and are never read before
        // being written by the current refill, so they carry no reset.
        if (state_q == READ && MemReady) begin
            case (word_q)
                2'd0:    slot0_q <= MemRdata;
                2'd1:    slot1_q <= MemRdata;
                2'd2:    slot2_q <= MemRdata;
                default: ;
            endcase
        end
    end

endmodule
